// File: rtl/saturate_clamp_pkg.sv
// Shared width defaults and helpers for the saturate_clamp pixel-pipeline clamp.
package saturate_clamp_pkg;

  localparam int DEF_IN_W  = 10;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_CNT_W = 16;

  // All-ones value of the given width, right-aligned in 32 bits.
  function automatic logic [31:0] sat_max(input int width);
    if (width >= 32) return '1;
    return (32'h1 << width) - 32'h1;
  endfunction

endpackage

// File: rtl/saturate_clamp_sat_counter.sv
// CNT_W-bit event counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = saturate_clamp_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/saturate_clamp.sv
// Unsigned saturating width reducer with saturation statistics.
// Define SATURATE_CLAMP_PIPE_EN to register out_data/sat (1 cycle latency).
module saturate_clamp
  import saturate_clamp_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             clr_stats,
  output logic [OUT_W-1:0] out_data,
  output logic             sat,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [OUT_W-1:0] MAX = OUT_W'(sat_max(OUT_W));

  logic             w_sat_now;
  logic             w_sat_event;
  logic [OUT_W-1:0] w_clamped;
  logic             r_sat_sticky;

  // Anything set above the output width means the value exceeds MAX.
  assign w_sat_now   = |in_data[IN_W-1:OUT_W];
  assign w_clamped   = w_sat_now ? MAX : in_data[OUT_W-1:0];
  assign w_sat_event = in_valid && w_sat_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_sticky <= 1'b0;
    end else if (clr_stats) begin
      r_sat_sticky <= 1'b0;
    end else if (w_sat_event) begin
      r_sat_sticky <= 1'b1;
    end
  end

  assign sat_sticky = r_sat_sticky;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_stats),
    .inc   (w_sat_event),
    .count (sat_count)
  );

`ifdef SATURATE_CLAMP_PIPE_EN
  logic [OUT_W-1:0] r_out_data;
  logic             r_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_out_data <= w_clamped;
      r_sat      <= w_sat_now;
    end
  end

  assign out_data = r_out_data;
  assign sat      = r_sat;
`else
  // Zero-latency path: the brightness stage registers nothing after the clamp.
  assign out_data = w_clamped;
  assign sat      = w_sat_now;
`endif

endmodule

// File: tb/tb_saturate_clamp.sv
// Self-checking bench for saturate_clamp (default CNT_W and CNT_W = 2 instances).
// Honours SATURATE_CLAMP_PIPE_EN when the bench is compiled with it.
module tb_saturate_clamp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       clr_stats = 1'b0;

  logic [7:0]  out_a, out_b;
  logic        sat_a, sat_b;
  logic        sticky_a, sticky_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_sticky = 0;
  int m_cnt_a  = 0;
  int m_cnt_b  = 0;
  int m_out    = 0;
  int m_sat    = 0;

  always #5 clk = ~clk;

  saturate_clamp #(.IN_W(10), .OUT_W(8), .CNT_W(16)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clr_stats  (clr_stats),
    .out_data   (out_a),
    .sat        (sat_a),
    .sat_sticky (sticky_a),
    .sat_count  (cnt_a)
  );

  saturate_clamp #(.IN_W(10), .OUT_W(8), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clr_stats  (clr_stats),
    .out_data   (out_b),
    .sat        (sat_b),
    .sat_sticky (sticky_b),
    .sat_count  (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int d);
    return (d > 255) ? 255 : d;
  endfunction

  task automatic step(input logic [9:0] d, input logic v, input logic c, input logic r);
    int val;
    val = int'(d);
    @(negedge clk);
    in_data   = d;
    in_valid  = v;
    clr_stats = c;
    rst       = r;
    #1;
`ifndef SATURATE_CLAMP_PIPE_EN
    check("out_data_a", 32'(out_a), 32'(clamp(val)));
    check("sat_a",      32'(sat_a), 32'(val > 255));
    check("out_data_b", 32'(out_b), 32'(clamp(val)));
`endif
    @(posedge clk);
    if (r) begin
      m_sticky = 0; m_cnt_a = 0; m_cnt_b = 0; m_out = 0; m_sat = 0;
    end else begin
      m_out = clamp(val);
      m_sat = (val > 255) ? 1 : 0;
      if (c) begin
        m_sticky = 0; m_cnt_a = 0; m_cnt_b = 0;
      end else if (v && val > 255) begin
        m_sticky = 1;
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 3)     m_cnt_b++;
      end
    end
    #1;
    check("sat_sticky_a", 32'(sticky_a), 32'(m_sticky));
    check("sat_count_a",  32'(cnt_a),    32'(m_cnt_a));
    check("sat_sticky_b", 32'(sticky_b), 32'(m_sticky));
    check("sat_count_b",  32'(cnt_b),    32'(m_cnt_b));
`ifdef SATURATE_CLAMP_PIPE_EN
    check("pipe_out_a", 32'(out_a), 32'(m_out));
    check("pipe_sat_a", 32'(sat_a), 32'(m_sat));
    check("pipe_out_b", 32'(out_b), 32'(m_out));
`endif
  endtask

  initial begin
    // Reset state
    step(10'h000, 1'b0, 1'b0, 1'b1);
    step(10'h000, 1'b0, 1'b0, 1'b0);
    // In-range and boundary values
    step(10'h0C8, 1'b1, 1'b0, 1'b0);
    step(10'h0FF, 1'b1, 1'b0, 1'b0);
    // Two qualified saturations
    step(10'h100, 1'b1, 1'b0, 1'b0);
    step(10'h3FF, 1'b1, 1'b0, 1'b0);
    // Saturation without in_valid leaves statistics alone
    step(10'h3FF, 1'b0, 1'b0, 1'b0);
    // Clear beats a simultaneous qualified event
    step(10'h200, 1'b1, 1'b1, 1'b0);
    step(10'h000, 1'b0, 1'b0, 1'b0);
    // Five qualified saturations: the 2-bit counter must hold at 3
    for (int i = 0; i < 5; i++) step(10'h200 + 10'(i), 1'b1, 1'b0, 1'b0);
    // Mid-stream reset with a qualified event present
    step(10'h155, 1'b1, 1'b0, 1'b1);
    step(10'h200, 1'b1, 1'b0, 1'b0);
    // Randomized traffic biased toward the saturation boundary
    for (int i = 0; i < 300; i++) begin
      logic [9:0] d;
      case ($urandom_range(0, 3))
        0:       d = 10'($urandom_range(0, 1023));
        1:       d = 10'($urandom_range(250, 262));
        2:       d = 10'($urandom_range(0, 255));
        default: d = 10'($urandom_range(256, 1023));
      endcase
      step(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
